sha256_block_ctrl: RTL

Sequencer that drives the combinational `sha256_transform` core over multi-block messages. Accepts pre-padded 512-bit message blocks over a valid/ready handshake and holds the 256-bit chaining state between blocks. Gives the transform a configurable number of settle cycles (multicycle path) and presents the final digest over a valid/ready handshake. Sits between the message padder/DMA front end and any digest consumer.

---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_transform.sv | 44 ++++
 rtl/sha256_block_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 block sequencer and its transform.
package sha256_pkg;

  localparam int BLK_W = 512;
  localparam int ST_W  = 256;

  // Initial hash value, H0 in the least significant word.
  localparam logic [ST_W-1:0] SHA256_IV =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

  // Round constants, K[0] first.
  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/sha256_transform.sv
// Combinational SHA-256 compression of one 512-bit block, feed-forward included.
// Word i of both buses sits at bits [32*i+31:32*i].
module sha256_transform
  import sha256_pkg::*;
(
  input  logic [ST_W-1:0]  state_in,
  input  logic [BLK_W-1:0] data_in,
  output logic [ST_W-1:0]  state_out
);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [ST_W-1:0] compress(input logic [ST_W-1:0] h_in,
                                               input logic [BLK_W-1:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) begin
      w[i] = blk[32*i +: 32];
    end
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h_in[31:0];    b = h_in[63:32];   c = h_in[95:64];   d = h_in[127:96];
    e = h_in[159:128]; f = h_in[191:160]; g = h_in[223:192]; h = h_in[255:224];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + SHA256_K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h_in[255:224] + h, h_in[223:192] + g, h_in[191:160] + f, h_in[159:128] + e,
            h_in[127:96] + d,  h_in[95:64] + c,   h_in[63:32] + b,   h_in[31:0] + a};
  endfunction

  assign state_out = compress(state_in, data_in);

endmodule

// File: rtl/sha256_block_ctrl.sv
// Multi-block SHA-256 sequencer: accepts padded blocks, runs the combinational
// transform for SETTLE_CYCLES cycles per block and hands out the final digest.
// The transform inputs (state_q, blk_q) only change on block accept, which is
// what makes the transform a SETTLE_CYCLES multicycle path. Legal SETTLE_CYCLES: 1..15.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  input  logic              blk_first,
  input  logic              blk_last,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic [ST_W-1:0]   digest,
  output logic              busy
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  ctrl_state_e      fsm_q, fsm_d;
  logic [ST_W-1:0]  chain_q, chain_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [ST_W-1:0]  state_q, state_d;
  logic             in_msg_q, in_msg_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             armed_q;
  logic [ST_W-1:0]  xform_out;
  logic             accept;

  sha256_transform u_xform (
    .state_in  (state_q),
    .data_in   (blk_q),
    .state_out (xform_out)
  );

  assign accept = (fsm_q == IDLE) && armed_q && blk_valid;

  // Next-state logic: block accept, settle countdown, digest hand-off.
  always_comb begin
    fsm_d    = fsm_q;
    chain_d  = chain_q;
    blk_d    = blk_q;
    state_d  = state_q;
    in_msg_d = in_msg_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          blk_d    = blk_data;
          last_d   = blk_last;
          // A first-flagged block, or any block with no message open, starts over from IV.
          state_d  = (blk_first || !in_msg_q) ? SHA256_IV : chain_q;
          in_msg_d = 1'b1;
          cnt_d    = 4'd0;
          fsm_d    = COMPUTE;
        end else begin
          fsm_d = IDLE;
        end
      end
      COMPUTE: begin
        if (cnt_q == CNT_LAST) begin
          chain_d = xform_out;
          fsm_d   = last_q ? DONE : IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (digest_ready) begin
          chain_d  = SHA256_IV;
          in_msg_d = 1'b0;
          fsm_d    = IDLE;
        end else begin
          fsm_d = DONE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      chain_q  <= SHA256_IV;
      blk_q    <= '0;
      state_q  <= '0;
      in_msg_q <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= 4'd0;
      armed_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      chain_q  <= chain_d;
      blk_q    <= blk_d;
      state_q  <= state_d;
      in_msg_q <= in_msg_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      armed_q  <= 1'b1;
    end
  end

  assign blk_ready    = (fsm_q == IDLE) && armed_q;
  assign digest_valid = (fsm_q == DONE);
  assign digest       = chain_q;
  assign busy         = (fsm_q != IDLE) || in_msg_q;

endmodule
